// File: rtl/test_counter.sv
// Free-running up-counter that wraps to zero at a programmable terminal value,
// with a one-cycle wrap flag for framing downstream DSP stages.
module test_counter #(
  parameter int WIDTH     = 8,
  parameter int STEP      = 1,
  parameter int MAX_VAL   = 255,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] counter,
  output logic             wrap
);

  // Any count above LIMIT would overshoot MAX_VAL on the next step.
  localparam logic [WIDTH-1:0] LIMIT  = WIDTH'(MAX_VAL - STEP);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] RST_W  = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] r_count;
  logic             w_at_limit;

  assign w_at_limit = (r_count > LIMIT);

  always_ff @(posedge clk) begin
    if (!reset)          r_count <= RST_W;
    else if (w_at_limit) r_count <= '0;
    else                 r_count <= r_count + STEP_W;
  end

  assign counter = r_count;
  assign wrap    = reset & w_at_limit;

endmodule

// File: tb/tb_test_counter.sv
// Scoreboard bench: three counter configurations driven by one reset stream,
// each checked every cycle against an arithmetic reference model.
module tb_test_counter;

  logic       clk;
  logic       rst;
  logic [7:0] cnt_a, cnt_c;
  logic [3:0] cnt_b;
  logic       wrap_a, wrap_b, wrap_c;

  test_counter u_a (.clk(clk), .reset(rst), .counter(cnt_a), .wrap(wrap_a));
  test_counter #(.WIDTH(4), .STEP(3), .MAX_VAL(9), .RESET_VAL(0))
    u_b (.clk(clk), .reset(rst), .counter(cnt_b), .wrap(wrap_b));
  test_counter #(.RESET_VAL(5))
    u_c (.clk(clk), .reset(rst), .counter(cnt_c), .wrap(wrap_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] ca, cb, cc;
    logic       wa, wb, wc;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Reference model: value held now, plus the configuration of each instance.
  int   m [3];
  int   MX[3] = '{255, 9, 255};
  int   ST[3] = '{1, 3, 1};
  int   RV[3] = '{0, 0, 5};
  bit   known = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    n_total++;
    if (act !== req) $display("FAIL %s: got %0d (%b) expected %0d", name, act, act, req);
    else n_pass++;
  endtask

  // One cycle: drive reset after the falling edge, record what the outputs
  // must show before the next rising edge, then advance the model across it.
  task automatic step(input logic r);
    exp_t e;
    int   c[3];
    bit   w[3];
    @(negedge clk);
    rst = r;
    if (known) begin
      for (int i = 0; i < 3; i++) begin
        c[i] = m[i];
        w[i] = r && (m[i] + ST[i] > MX[i]);
      end
      e.ca = 8'(c[0]); e.cb = 8'(c[1]); e.cc = 8'(c[2]);
      e.wa = w[0];     e.wb = w[1];     e.wc = w[2];
      sb.push_back(e);
    end
    for (int i = 0; i < 3; i++) begin
      if (!r)                     m[i] = RV[i];
      else if (m[i] + ST[i] > MX[i]) m[i] = 0;
      else                        m[i] = m[i] + ST[i];
    end
    if (!r) known = 1;
  endtask

  // Monitor: outputs are valid every cycle once reset has been applied.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("cnt_default", cnt_a, e.ca);
        chk("wrap_default", {7'd0, wrap_a}, {7'd0, e.wa});
        chk("cnt_step3", {4'd0, cnt_b}, e.cb);
        chk("wrap_step3", {7'd0, wrap_b}, {7'd0, e.wb});
        chk("cnt_rst5", cnt_c, e.cc);
        chk("wrap_rst5", {7'd0, wrap_c}, {7'd0, e.wc});
      end
    end
  end

  initial begin
    int guard;
    rst = 1'b0;
    step(0); step(0); step(0);
    // Run through a full wrap of the default counter.
    for (int k = 0; k < 300; k++) step(1);
    // Mid-count reset at 100.
    guard = 0;
    while (m[0] != 100 && guard < 400) begin step(1); guard++; end
    step(0);
    for (int k = 0; k < 10; k++) step(1);
    // Reset on the cycle the default counter sits at 255.
    guard = 0;
    while (m[0] != 255 && guard < 400) begin step(1); guard++; end
    step(0);
    for (int k = 0; k < 5; k++) step(1);
    // Long reset hold.
    for (int k = 0; k < 8; k++) step(0);
    // Random reset pulses.
    for (int k = 0; k < 1500; k++) step($urandom_range(0, 19) != 0);
    // Let the monitor drain the scoreboard, bounded.
    guard = 0;
    while (sb.size() > 0 && guard < 20) begin @(negedge clk); guard++; end
    @(negedge clk); #3;
    n_total++;
    if (sb.size() != 0) $display("FAIL drain: %0d entries left, expected 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
